lsu_mem_access: RTL
===================

Name: lsu_mem_access

Overview:
- Load/store unit that takes the aligned address and 2-bit byte offset produced by the ALU and runs the data-memory bus transaction.
- For stores it generates byte enables and replicated write data.
- For loads it extracts, extends or merges the returned data into a 32-bit register-file value.
- Sits between the execute stage and the Avalon-style data bus; holds the CPU stalled (busy) until the transfer completes.

Parameters:
- ADDR_W, 32, width of data bus address.
- MAX_WAIT, 255, waitrequest cycles tolerated before timeout error; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- start  in  1  request pulse; sampled only in IDLE
- mem_op  in  4  operation code (mem_op_t)
- addr  in  ADDR_W  word-aligned address (low 2 bits ignored)
- byte_offset  in  2  byte lane within the word
- store_data  in  32  rt value for stores
- rt_old  in  32  current rt value, used for LWL/LWR merge
- data_address  out  ADDR_W  bus address, low 2 bits always 0
- data_read  out  1  bus read strobe
- data_write  out  1  bus write strobe
- data_byteenable  out  4  active byte lanes
- data_writedata  out  32  bus write data
- data_waitrequest  in  1  slave stall
- data_readdata  in  32  bus read data, valid in the cycle waitrequest=0 with read asserted
- busy  out  1  high from the cycle after an accepted start until DONE
- done  out  1  one-cycle completion pulse
- load_result  out  32  register write-back value, valid while done=1
- error  out  1  one-cycle pulse with done on misalignment or timeout

Behaviour:
- Reset is synchronous and active-low: reset_n=0 at a clk edge forces IDLE. All outputs go to 0, the wait counter clears, and captured data clears. This applies mid-transfer too: the strobe drops the same edge.
- Byte order is little-endian: lane k is readdata[8k+7:8k].
- FSM states: IDLE, REQ, DONE.
  - IDLE: start=1 latches mem_op/addr/offset/store_data/rt_old.
    - If misaligned, go to DONE with error=1 and perform no bus access. Misaligned means LH/LHU/SH with offset[0]=1, or LW/SW with offset≠0.
    - Otherwise go to REQ.
  - REQ: assert data_read or data_write with stable address, byteenable and writedata.
    - waitrequest=1: hold everything and increment the wait counter.
    - waitrequest=0: capture readdata and go to DONE.
    - Wait counter reaching MAX_WAIT (when MAX_WAIT≠0): drop the strobe, go to DONE with error=1, and set load_result=0.
  - DONE: done=1 and busy=0 for exactly one cycle, then IDLE. A start asserted in DONE is ignored.
- Minimum latency is start edge → done = 2 cycles with zero wait.
- start asserted while not IDLE is ignored.
- Store lanes:
  - SB: byteenable = 1<<k, writedata = {4{rt[7:0]}}.
  - SH: k=0 gives 0011, k=2 gives 1100; writedata = {2{rt[15:0]}}.
  - SW: byteenable 1111.
- Load reads always use byteenable 1111.
- Load extraction, with k the byte offset and W the captured word:
  - LB/LBU: sign- or zero-extend lane k.
  - LH/LHU: sign- or zero-extend bytes [k+1:k].
  - LW: W.
  - LWL: (W << 8(3−k)) | (rt_old & low-mask of 8(3−k) bits).
  - LWR: (W >> 8k) | (rt_old & high-mask of 8k bits).
- Store ops give load_result=0.
- load_result holds its value until the next start is accepted.

Decomposition:
- A shared package cpu_pkg holds the mem_op_t enum (LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW) and the lsu_state_t enum (IDLE, REQ, DONE).
- One combinational sub-module, load_align, maps (mem_op, byte_offset, readdata, rt_old) to load_result and is reused for unit testing.

Test Plan:
- SB, addr=0x100, offset=2, rt=0x000000A5, waitrequest=0 → data_write one cycle, byteenable=0100, writedata=0xA5A5A5A5; done 2 cycles after start.
- LB, offset=3, readdata=0x80112233, 2 wait cycles → busy 3 cycles, load_result=0xFFFFFF80; LBU with the same stimulus → 0x00000080.
- LWL, offset=1, readdata=0xAABBCCDD, rt_old=0x11223344 → 0xCCDD3344; LWR offset=1 with the same data → 0x11AABBCC.
- LW, offset=2 → no data_read, done and error both high the cycle after start, load_result=0.
- LW with waitrequest held high and MAX_WAIT=4 → read asserted for 4 cycles, then done+error, strobe low.
- reset_n=0 for one edge during REQ with waitrequest=1 → next cycle data_read=0, busy=0, done=0; a following start is accepted normally.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU types and helpers for the load/store unit.
// Provides the memory op and LSU state enums, the latched request payload,
// and small pure functions for alignment checks and store lane formatting.
package cpu_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;

  typedef enum logic [3:0] {
    LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW
  } mem_op_t;

  typedef enum logic [1:0] {
    IDLE, REQ, DONE
  } lsu_state_t;

  // Request fields held for the whole transfer
  typedef struct packed {
    mem_op_t           op;
    logic [1:0]        off;
    logic [DATA_W-1:0] rt_old;
  } lsu_req_t;

  function automatic logic op_is_store(mem_op_t op);
    return (op == SB) || (op == SH) || (op == SW);
  endfunction

  // Halfwords need an even lane, full words need lane 0; LWL/LWR are never misaligned
  function automatic logic op_misaligned(mem_op_t op, logic [1:0] off);
    case (op)
      LH, LHU, SH: return off[0];
      LW, SW:      return off != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  function automatic logic [BE_W-1:0] store_byteenable(mem_op_t op, logic [1:0] off);
    case (op)
      SB:      return 4'b0001 << off;
      SH:      return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] store_writedata(mem_op_t op, logic [DATA_W-1:0] d);
    case (op)
      SB:      return {4{d[7:0]}};
      SH:      return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/lsu_mem_access_if.sv
// Avalon-style data bus between the LSU (master) and data memory (slave).
// Ports: data_address/read/write/byteenable/writedata from master,
//        data_waitrequest/readdata from slave.
interface lsu_mem_access_if #(
  parameter int unsigned ADDR_W = 32
) ();

  logic [ADDR_W-1:0] data_address;
  logic              data_read;
  logic              data_write;
  logic [3:0]        data_byteenable;
  logic [31:0]       data_writedata;
  logic              data_waitrequest;
  logic [31:0]       data_readdata;

  modport master (
    output data_address, data_read, data_write, data_byteenable, data_writedata,
    input  data_waitrequest, data_readdata
  );

  modport slave (
    input  data_address, data_read, data_write, data_byteenable, data_writedata,
    output data_waitrequest, data_readdata
  );

endinterface

// File: rtl/load_align.sv
// Combinational load formatter: turns the returned bus word into the
// register write-back value (extend, or merge with old rt for LWL/LWR).
// Ports: i_mem_op, i_byte_offset, i_readdata, i_rt_old in; o_load_result_c out.
module load_align
  import cpu_pkg::*;
(
  input  mem_op_t           i_mem_op,
  input  logic [1:0]        i_byte_offset,
  input  logic [DATA_W-1:0] i_readdata,
  input  logic [DATA_W-1:0] i_rt_old,
  output logic [DATA_W-1:0] o_load_result_c
);

  logic [4:0]        w_sh_k;
  logic [4:0]        w_sh_inv;
  logic [DATA_W-1:0] w_shr;
  logic [DATA_W-1:0] w_shl;

  // 8*k and 8*(3-k); for a 2-bit k, 3-k is just ~k
  assign w_sh_k   = {i_byte_offset, 3'b000};
  assign w_sh_inv = {~i_byte_offset, 3'b000};
  assign w_shr    = i_readdata >> w_sh_k;
  assign w_shl    = i_readdata << w_sh_inv;

  always_comb begin
    o_load_result_c = '0;
    case (i_mem_op)
      LB:  o_load_result_c = {{24{w_shr[7]}}, w_shr[7:0]};
      LBU: o_load_result_c = {24'd0, w_shr[7:0]};
      LH:  o_load_result_c = {{16{w_shr[15]}}, w_shr[15:0]};
      LHU: o_load_result_c = {16'd0, w_shr[15:0]};
      LW:  o_load_result_c = i_readdata;
      LWL: o_load_result_c = w_shl | (i_rt_old & ~(32'hFFFF_FFFF << w_sh_inv));
      LWR: o_load_result_c = w_shr | (i_rt_old & ~(32'hFFFF_FFFF >> w_sh_k));
      default: o_load_result_c = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_access.sv
// Load/store unit: runs one data-bus transaction per accepted start,
// formats store lanes, aligns load data, and flags misalignment/timeouts.
// Ports: clk, reset_n (sync active-low); start/mem_op/addr/byte_offset/
//        store_data/rt_old from execute; bus (master modport);
//        busy/done/load_result/error back to the pipeline.
module lsu_mem_access
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  mem_op_t           mem_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        byte_offset,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rt_old,
  lsu_mem_access_if.master  bus,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] load_result,
  output logic              error
);

  localparam int unsigned CNT_W = (MAX_WAIT == 0) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);
  localparam logic TIMEOUT_EN = (MAX_WAIT != 0);

  lsu_state_t        r_state, w_state_nxt;
  lsu_req_t          r_req, w_req_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_address, w_address_nxt;
  logic [BE_W-1:0]   r_be, w_be_nxt;
  logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
  logic              r_read, w_read_nxt;
  logic              r_write, w_write_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_error, w_error_nxt;
  logic [DATA_W-1:0] r_load_result, w_load_result_nxt;
  logic [DATA_W-1:0] w_align;
  logic              w_unused_addr_lo;

  // Address low bits are carried by byte_offset instead
  assign w_unused_addr_lo = ^addr[1:0];

  load_align u_load_align (
    .i_mem_op        (r_req.op),
    .i_byte_offset   (r_req.off),
    .i_readdata      (bus.data_readdata),
    .i_rt_old        (r_req.rt_old),
    .o_load_result_c (w_align)
  );

  // Next state and next registered outputs
  always_comb begin
    w_state_nxt       = r_state;
    w_req_nxt         = r_req;
    w_cnt_nxt         = r_cnt;
    w_address_nxt     = r_address;
    w_be_nxt          = r_be;
    w_wdata_nxt       = r_wdata;
    w_read_nxt        = 1'b0;
    w_write_nxt       = 1'b0;
    w_busy_nxt        = 1'b0;
    w_done_nxt        = 1'b0;
    w_error_nxt       = 1'b0;
    w_load_result_nxt = r_load_result;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_req_nxt.op      = mem_op;
          w_req_nxt.off     = byte_offset;
          w_req_nxt.rt_old  = rt_old;
          w_cnt_nxt         = '0;
          w_address_nxt     = {addr[ADDR_W-1:2], 2'b00};
          w_be_nxt          = store_byteenable(mem_op, byte_offset);
          w_wdata_nxt       = store_writedata(mem_op, store_data);
          w_load_result_nxt = '0;
          if (op_misaligned(mem_op, byte_offset)) begin
            w_state_nxt = DONE;
            w_done_nxt  = 1'b1;
            w_error_nxt = 1'b1;
          end else begin
            w_state_nxt = REQ;
            w_busy_nxt  = 1'b1;
            w_read_nxt  = !op_is_store(mem_op);
            w_write_nxt = op_is_store(mem_op);
          end
        end
      end

      REQ: begin
        if (bus.data_waitrequest) begin
          // Timeout fires on the stall that would bring the count to MAX_WAIT
          if (TIMEOUT_EN && (r_cnt == CNT_LAST)) begin
            w_state_nxt       = DONE;
            w_done_nxt        = 1'b1;
            w_error_nxt       = 1'b1;
            w_load_result_nxt = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
            w_busy_nxt  = 1'b1;
            w_read_nxt  = r_read;
            w_write_nxt = r_write;
          end
        end else begin
          w_state_nxt       = DONE;
          w_done_nxt        = 1'b1;
          w_load_result_nxt = w_align;
        end
      end

      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_req         <= '0;
      r_cnt         <= '0;
      r_address     <= '0;
      r_be          <= '0;
      r_wdata       <= '0;
      r_read        <= 1'b0;
      r_write       <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_load_result <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_req         <= w_req_nxt;
      r_cnt         <= w_cnt_nxt;
      r_address     <= w_address_nxt;
      r_be          <= w_be_nxt;
      r_wdata       <= w_wdata_nxt;
      r_read        <= w_read_nxt;
      r_write       <= w_write_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
      r_error       <= w_error_nxt;
      r_load_result <= w_load_result_nxt;
    end
  end

  assign bus.data_address    = r_address;
  assign bus.data_read       = r_read;
  assign bus.data_write      = r_write;
  assign bus.data_byteenable = r_be;
  assign bus.data_writedata  = r_wdata;
  assign busy                = r_busy;
  assign done                = r_done;
  assign error               = r_error;
  assign load_result         = r_load_result;

endmodule
